// File: rtl/vector_execute_pipe.sv
// Multi-cycle scalar/vector execute unit: ALU ops take 1 (scalar) or PASSES cycles, DIV one quotient bit per cycle.
// Accepts only in IDLE; result and flags are held in DONE until out_ready, with one bubble before the next accept.
module vector_execute_pipe #(
    parameter int SCALAR_WIDTH    = 19,
    parameter int LANE_WIDTH      = 8,
    parameter int LANES           = 8,
    parameter int LANES_PER_CYCLE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  mode,
    input  logic [1:0]                  alu_op,
    input  logic                        use_imm,
    input  logic [SCALAR_WIDTH-1:0]     scalar_a,
    input  logic [SCALAR_WIDTH-1:0]     scalar_b,
    input  logic [SCALAR_WIDTH-1:0]     imm,
    input  logic [LANES*LANE_WIDTH-1:0] vec_a,
    input  logic [LANES*LANE_WIDTH-1:0] vec_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*LANE_WIDTH-1:0] out_data,
    output logic                        flag_n,
    output logic                        flag_z,
    output logic                        flag_v,
    output logic                        flag_c,
    output logic                        div_by_zero
);
    localparam int SW        = SCALAR_WIDTH;
    localparam int LW        = LANE_WIDTH;
    localparam int LPC       = LANES_PER_CYCLE;
    localparam int VecW      = LANES * LANE_WIDTH;
    localparam int ChunkBits = LPC * LW;
    localparam int Passes    = LANES / LPC;
    localparam int ChunkW    = (Passes > 1) ? $clog2(Passes) : 1;
    localparam int CntW      = $clog2(SW);
    localparam logic [1:0] OpAdd = 2'b00, OpSub = 2'b01, OpDiv = 2'b10, OpMul = 2'b11;

    typedef enum logic [1:0] {Idle, Run, Div, Done} state_t;

    state_t              state;
    logic                isVec, isVv;
    logic [1:0]          op;
    logic [VecW-1:0]     aVec, bVec;
    logic [SW-1:0]       sA, sB;
    logic [ChunkW-1:0]   chunk;
    logic [CntW-1:0]     bitCnt;
    logic [SW-1:0]       divQuo [LPC];
    logic [SW-1:0]       divRem [LPC];
    logic [SW-1:0]       divDen [LPC];

    logic [SW:0]         scSum;
    logic [SW-1:0]       scRes;
    logic                scC, scV;
    logic [ChunkBits-1:0] aluChunk, divChunk;
    logic [SW-1:0]       nextQuo [LPC];
    logic [SW-1:0]       nextRem [LPC];
    logic [SW-1:0]       ldQuo [LPC];
    logic [SW-1:0]       ldDen [LPC];
    logic [VecW-1:0]     mergedAlu, mergedDiv;
    logic                anyZeroLane;
    logic [SW:0]         trial;
    logic                qBit;
    logic [LW-1:0]       la, lb;
    int                  laneIdx, srcIdx;

    // Divider loads come straight from the inputs on accept, from latched operands between chunks.
    logic                loadFromInput, srcVec, srcVv;
    logic [VecW-1:0]     srcVecA, srcVecB;
    logic [SW-1:0]       srcScA, srcScB;
    logic [ChunkW-1:0]   srcChunk;
    logic                lastChunk;

    assign in_ready      = (state == Idle) && !rst;
    assign loadFromInput = (state == Idle);
    assign srcVec        = loadFromInput ? (mode[0] ^ mode[1]) : isVec;
    assign srcVv         = loadFromInput ? (mode == 2'b10) : isVv;
    assign srcVecA       = loadFromInput ? vec_a : aVec;
    assign srcVecB       = loadFromInput ? vec_b : bVec;
    assign srcScA        = loadFromInput ? scalar_a : sA;
    assign srcScB        = loadFromInput ? (use_imm ? imm : scalar_b) : sB;
    assign srcChunk      = loadFromInput ? '0 : chunk + 1'b1;
    assign lastChunk     = (chunk == ChunkW'(Passes - 1));

    always_comb begin
        scSum = {1'b0, sA} + {1'b0, sB};
        scRes = '0;
        scC   = 1'b0;
        scV   = 1'b0;
        case (op)
            OpAdd: begin
                scRes = scSum[SW-1:0];
                scC   = scSum[SW];
                scV   = (sA[SW-1] == sB[SW-1]) && (scRes[SW-1] != sA[SW-1]);
            end
            OpSub: begin
                scRes = sA - sB;
                scC   = (sA >= sB);
                scV   = (sA[SW-1] != sB[SW-1]) && (scRes[SW-1] != sA[SW-1]);
            end
            OpMul:   scRes = sA * sB;
            default: scRes = '0;
        endcase
    end

    always_comb begin
        aluChunk = '0;
        divChunk = '0;
        laneIdx  = 0;
        srcIdx   = 0;
        la       = '0;
        lb       = '0;
        trial    = '0;
        qBit     = 1'b0;
        for (int j = 0; j < LPC; j++) begin
            laneIdx = int'(chunk) * LPC + j;
            la = aVec[laneIdx*LW +: LW];
            lb = isVv ? bVec[laneIdx*LW +: LW] : sB[LW-1:0];
            case (op)
                OpAdd:   aluChunk[j*LW +: LW] = la + lb;
                OpSub:   aluChunk[j*LW +: LW] = la - lb;
                OpMul:   aluChunk[j*LW +: LW] = la * lb;
                default: aluChunk[j*LW +: LW] = '0;
            endcase

            // Restoring step; a zero divisor always "fits", so x/0 yields all ones.
            trial      = {divRem[j], divQuo[j][SW-1]};
            qBit       = 1'b0;
            nextRem[j] = trial[SW-1:0];
            if (trial >= {1'b0, divDen[j]}) begin
                qBit       = 1'b1;
                nextRem[j] = SW'(trial - {1'b0, divDen[j]});
            end
            nextQuo[j] = {divQuo[j][SW-2:0], qBit};
            divChunk[j*LW +: LW] = nextQuo[j][LW-1:0];

            srcIdx = int'(srcChunk) * LPC + j;
            if (srcVec) begin
                ldQuo[j] = SW'(srcVecA[srcIdx*LW +: LW]) << (SW - LW);
                ldDen[j] = SW'(srcVv ? srcVecB[srcIdx*LW +: LW] : srcScB[LW-1:0]);
            end else begin
                ldQuo[j] = (j == 0) ? srcScA : '0;
                ldDen[j] = (j == 0) ? srcScB : '0;
            end
        end
    end

    always_comb begin
        mergedAlu = out_data;
        mergedAlu[int'(chunk)*ChunkBits +: ChunkBits] = aluChunk;
        mergedDiv = out_data;
        mergedDiv[int'(chunk)*ChunkBits +: ChunkBits] = divChunk;
        anyZeroLane = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((isVv ? bVec[i*LW +: LW] : sB[LW-1:0]) == '0) anyZeroLane = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= Idle;
            out_valid   <= 1'b0;
            out_data    <= '0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
            flag_v      <= 1'b0;
            flag_c      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                Idle: if (in_valid) begin
                    isVec  <= mode[0] ^ mode[1];
                    isVv   <= (mode == 2'b10);
                    op     <= alu_op;
                    aVec   <= vec_a;
                    bVec   <= vec_b;
                    sA     <= scalar_a;
                    sB     <= use_imm ? imm : scalar_b;
                    chunk  <= '0;
                    bitCnt <= '0;
                    for (int j = 0; j < LPC; j++) begin
                        divQuo[j] <= ldQuo[j];
                        divDen[j] <= ldDen[j];
                        divRem[j] <= '0;
                    end
                    state <= (alu_op == OpDiv) ? Div : Run;
                end
                Run: begin
                    if (!isVec) begin
                        out_data    <= VecW'(scRes);
                        flag_n      <= scRes[SW-1];
                        flag_z      <= (scRes == '0);
                        flag_v      <= scV;
                        flag_c      <= scC;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= Done;
                    end else begin
                        out_data <= mergedAlu;
                        if (lastChunk) begin
                            flag_n      <= 1'b0;
                            flag_z      <= (mergedAlu == '0);
                            flag_v      <= 1'b0;
                            flag_c      <= 1'b0;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= Done;
                        end else begin
                            chunk <= chunk + 1'b1;
                        end
                    end
                end
                Div: begin
                    for (int j = 0; j < LPC; j++) begin
                        divQuo[j] <= nextQuo[j];
                        divRem[j] <= nextRem[j];
                    end
                    bitCnt <= bitCnt + 1'b1;
                    if (!isVec && bitCnt == CntW'(SW - 1)) begin
                        out_data    <= VecW'(nextQuo[0]);
                        flag_n      <= nextQuo[0][SW-1];
                        flag_z      <= (nextQuo[0] == '0);
                        flag_v      <= 1'b0;
                        flag_c      <= 1'b0;
                        div_by_zero <= (sB == '0);
                        out_valid   <= 1'b1;
                        state       <= Done;
                    end else if (isVec && bitCnt == CntW'(LW - 1)) begin
                        out_data <= mergedDiv;
                        bitCnt   <= '0;
                        if (lastChunk) begin
                            flag_n      <= 1'b0;
                            flag_z      <= (mergedDiv == '0);
                            flag_v      <= 1'b0;
                            flag_c      <= 1'b0;
                            div_by_zero <= anyZeroLane;
                            out_valid   <= 1'b1;
                            state       <= Done;
                        end else begin
                            chunk <= chunk + 1'b1;
                            for (int j = 0; j < LPC; j++) begin
                                divQuo[j] <= ldQuo[j];
                                divDen[j] <= ldDen[j];
                                divRem[j] <= '0;
                            end
                        end
                    end
                end
                Done: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= Idle;
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_execute_pipe.sv
// Bench for vector_execute_pipe: directed cases, randomized ops against an arithmetic model,
// backpressure hold and reset during a vector divide.
module tb_vector_execute_pipe;
    localparam int SW = 19;
    localparam int LW = 8;
    localparam int LN = 8;
    localparam int VW = LN * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    mode = 2'b00;
    logic [1:0]    alu_op = 2'b00;
    logic          use_imm = 1'b0;
    logic [SW-1:0] scalar_a = '0, scalar_b = '0, imm = '0;
    logic [VW-1:0] vec_a = '0, vec_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
    logic          flag_n, flag_z, flag_v, flag_c, div_by_zero;

    int nTests = 0;
    int nFail  = 0;

    vector_execute_pipe #(
        .SCALAR_WIDTH(SW), .LANE_WIDTH(LW), .LANES(LN), .LANES_PER_CYCLE(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .alu_op(alu_op), .use_imm(use_imm),
        .scalar_a(scalar_a), .scalar_b(scalar_b), .imm(imm),
        .vec_a(vec_a), .vec_b(vec_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Expected result, flags {n,z,v,c,dbz} and latency from plain integer arithmetic.
    function automatic void refModel(input logic [1:0] m, input logic [1:0] o, input logic ui,
                                     input logic [SW-1:0] a, input logic [SW-1:0] b,
                                     input logic [SW-1:0] im, input logic [VW-1:0] va,
                                     input logic [VW-1:0] vb, output logic [VW-1:0] d,
                                     output logic [4:0] f, output int lat);
        longint M, half, ua, ub, sa, sb, r, sr, la, lb, lr;
        logic n, z, v, c, dz;
        logic [SW-1:0] bsel;
        bsel = ui ? im : b;
        M = longint'(1) << SW;
        half = M / 2;
        n = 0; z = 0; v = 0; c = 0; dz = 0; d = '0; r = 0;
        if (m == 2'b01 || m == 2'b10) begin
            for (int i = 0; i < LN; i++) begin
                la = longint'(va[i*LW +: LW]);
                lb = (m == 2'b10) ? longint'(vb[i*LW +: LW]) : longint'(bsel[LW-1:0]);
                case (o)
                    2'b00: lr = (la + lb) % 256;
                    2'b01: lr = (la - lb + 256) % 256;
                    2'b11: lr = (la * lb) % 256;
                    default: begin
                        if (lb == 0) begin lr = 255; dz = 1; end
                        else lr = la / lb;
                    end
                endcase
                d[i*LW +: LW] = lr[LW-1:0];
            end
            z = (d == '0);
            lat = (o == 2'b10) ? (LN / 2) * LW : LN / 2;
        end else begin
            ua = longint'(a);
            ub = longint'(bsel);
            sa = (ua >= half) ? ua - M : ua;
            sb = (ub >= half) ? ub - M : ub;
            case (o)
                2'b00: begin
                    r = ua + ub; c = (r >= M); r = r % M;
                    sr = sa + sb; v = (sr >= half) || (sr < -half);
                end
                2'b01: begin
                    r = ua - ub; c = (ua >= ub); if (r < 0) r = r + M;
                    sr = sa - sb; v = (sr >= half) || (sr < -half);
                end
                2'b11: r = (ua * ub) % M;
                default: begin
                    if (ub == 0) begin r = M - 1; dz = 1; end
                    else r = ua / ub;
                end
            endcase
            n = (r >= half);
            z = (r == 0);
            d[SW-1:0] = r[SW-1:0];
            lat = (o == 2'b10) ? SW : 1;
        end
        f = {n, z, v, c, dz};
    endfunction

    // Issues one op, then scrambles the inputs; returns latency, data, flags and out_valid after handshake.
    task automatic runOp(input logic [1:0] m, input logic [1:0] o, input logic ui,
                         input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] im,
                         input logic [VW-1:0] va, input logic [VW-1:0] vb,
                         output int lat, output logic [VW-1:0] d, output logic [4:0] f,
                         output logic vldAfter);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1; mode = m; alu_op = o; use_imm = ui;
        scalar_a = a; scalar_b = b; imm = im; vec_a = va; vec_b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode = 2'($urandom); alu_op = 2'($urandom); use_imm = 1'($urandom);
        scalar_a = SW'($urandom); scalar_b = SW'($urandom); imm = SW'($urandom);
        vec_a = {$urandom, $urandom}; vec_b = {$urandom, $urandom};
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (out_valid !== 1'b1 && lat < 200);
        d = out_data;
        f = {flag_n, flag_z, flag_v, flag_c, div_by_zero};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vldAfter = out_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nTests++;
        if ({in_ready, out_valid, out_data, flag_n, flag_z, flag_v, flag_c, div_by_zero} !== '0) begin
            nFail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h flags=%b%b%b%b%b, required all zero",
                     in_ready, out_valid, out_data, flag_n, flag_z, flag_v, flag_c, div_by_zero);
        end
        rst = 1'b0;
        #1;
        nTests++;
        if (in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    typedef struct {
        string         nm;
        logic [1:0]    m, o;
        logic          ui;
        logic [SW-1:0] a, b, im;
        logic [VW-1:0] va, vb, ed;
        logic [4:0]    ef;
        int            el;
    } dir_t;

    task automatic test_directed;
        dir_t          t[$];
        int            lat;
        logic [VW-1:0] d;
        logic [4:0]    f;
        logic          va;
        t.push_back('{"add_3_1",   2'd0, 2'd0, 1'b0, 19'd3, 19'd1, 19'd0, '0, '0, 64'd4, 5'b00000, 1});
        t.push_back('{"sub_3_1",   2'd0, 2'd1, 1'b0, 19'd3, 19'd1, 19'd0, '0, '0, 64'd2, 5'b00010, 1});
        t.push_back('{"div_6_2",   2'd0, 2'd2, 1'b0, 19'd6, 19'd2, 19'd0, '0, '0, 64'd3, 5'b00000, 19});
        t.push_back('{"div_5_0",   2'd0, 2'd2, 1'b0, 19'd5, 19'd0, 19'd0, '0, '0, 64'h7FFFF, 5'b10001, 19});
        t.push_back('{"mul_6_2",   2'd0, 2'd3, 1'b0, 19'd6, 19'd2, 19'd0, '0, '0, 64'd12, 5'b00000, 1});
        t.push_back('{"add_imm_wrap", 2'd0, 2'd0, 1'b1, 19'h7FFFF, 19'h12345, 19'd1, '0, '0, 64'd0, 5'b01010, 1});
        t.push_back('{"mode3_add_ovf", 2'd3, 2'd0, 1'b0, 19'h3FFFF, 19'd1, 19'd0, '0, '0, 64'h40000, 5'b10100, 1});
        t.push_back('{"vs_add", 2'd1, 2'd0, 1'b0, 19'd0, 19'd2, 19'd0, 64'h0500050305020401, '0,
                      64'h0702070507040603, 5'b00000, 4});
        t.push_back('{"vv_sub", 2'd2, 2'd1, 1'b0, 19'd0, 19'd0, 19'd0, 64'h0502050305020401,
                      64'h0101010101010101, 64'h0401040204010300, 5'b00000, 4});
        t.push_back('{"vv_sub_wrap", 2'd2, 2'd1, 1'b0, 19'd0, 19'd0, 19'd0, 64'h0, 64'h0101010101010101,
                      64'hFFFFFFFFFFFFFFFF, 5'b00000, 4});
        t.push_back('{"vv_div_zero_lane", 2'd2, 2'd2, 1'b0, 19'd0, 19'd0, 19'd0, 64'h0000000000000C07,
                      64'h0101010101010003, 64'h000000000000FF02, 5'b00001, 32});
        foreach (t[k]) begin
            runOp(t[k].m, t[k].o, t[k].ui, t[k].a, t[k].b, t[k].im, t[k].va, t[k].vb, lat, d, f, va);
            nTests++;
            if (lat !== t[k].el) begin
                nFail++;
                $display("FAIL %s latency: got %0d required %0d", t[k].nm, lat, t[k].el);
            end
            nTests++;
            if (d !== t[k].ed) begin
                nFail++;
                $display("FAIL %s data: got %h required %h", t[k].nm, d, t[k].ed);
            end
            nTests++;
            if (f !== t[k].ef) begin
                nFail++;
                $display("FAIL %s flags(nzvc,dbz): got %b required %b", t[k].nm, f, t[k].ef);
            end
            nTests++;
            if (va !== 1'b0) begin
                nFail++;
                $display("FAIL %s out_valid_after_ready: got %b required 0", t[k].nm, va);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]    m, o;
        logic          ui, va;
        logic [SW-1:0] a, b, im;
        logic [VW-1:0] vaa, vbb, d, ed;
        logic [4:0]    f, ef;
        int            lat, el;
        for (int k = 0; k < 30; k++) begin
            m = 2'($urandom); o = 2'($urandom); ui = 1'($urandom);
            a = SW'($urandom); b = SW'($urandom); im = SW'($urandom);
            if ($urandom_range(0, 3) == 0) b = SW'($urandom_range(0, 2));
            vaa = {$urandom, $urandom}; vbb = {$urandom, $urandom};
            for (int i = 0; i < LN; i++)
                if ($urandom_range(0, 7) == 0) vbb[i*LW +: LW] = '0;
            refModel(m, o, ui, a, b, im, vaa, vbb, ed, ef, el);
            runOp(m, o, ui, a, b, im, vaa, vbb, lat, d, f, va);
            nTests++;
            if (lat !== el || d !== ed || f !== ef || va !== 1'b0) begin
                nFail++;
                $display("FAIL random[%0d] m=%0d op=%0d: got lat=%0d data=%h flags=%b vld=%b required lat=%0d data=%h flags=%b vld=0",
                         k, m, o, lat, d, f, va, el, ed, ef);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [VW-1:0] held, ed, vaa;
        logic [4:0]    ef;
        int            el, w, seen;
        vaa = {$urandom, $urandom};
        refModel(2'd1, 2'd3, 1'b0, '0, 19'd3, '0, vaa, '0, ed, ef, el);
        in_valid = 1'b1; mode = 2'd1; alu_op = 2'd3; use_imm = 1'b0;
        scalar_b = 19'd3; vec_a = vaa;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        nTests++;
        if (out_data !== ed) begin
            nFail++;
            $display("FAIL bp_result: got %h required %h", out_data, ed);
        end
        held = ed;
        in_valid = 1'b1; mode = 2'd0; alu_op = 2'd0; scalar_a = 19'd9; vec_a = ~vaa;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nTests++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, held}) begin
                nFail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%h required vld=1 rdy=0 data=%h",
                         c, out_valid, in_ready, out_data, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nTests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nFail++;
            $display("FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        nTests++;
        if (seen !== 0) begin
            nFail++;
            $display("FAIL bp_ignored_request: got %0d valid cycles required 0", seen);
        end
    endtask

    task automatic test_reset_mid_div;
        logic [SW-1:0] a, b;
        logic [VW-1:0] d, ed;
        logic [4:0]    f, ef;
        logic          va;
        int            lat, el, seen;
        in_valid = 1'b1; mode = 2'd2; alu_op = 2'd2; use_imm = 1'b0;
        vec_a = {$urandom, $urandom}; vec_b = 64'h0303030303030303;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        nTests++;
        if ({out_valid, in_ready} !== 2'b00) begin
            nFail++;
            $display("FAIL rst_mid_div: got vld=%b rdy=%b required 0 0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        nTests++;
        if (in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL rst_mid_div_ready: got %b required 1", in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        nTests++;
        if (seen !== 0) begin
            nFail++;
            $display("FAIL rst_mid_div_discard: got %0d valid cycles required 0", seen);
        end
        a = SW'($urandom); b = SW'($urandom_range(1, 1000));
        refModel(2'd0, 2'd2, 1'b0, a, b, '0, '0, '0, ed, ef, el);
        runOp(2'd0, 2'd2, 1'b0, a, b, '0, '0, '0, lat, d, f, va);
        nTests++;
        if (d !== ed || f !== ef || lat !== el) begin
            nFail++;
            $display("FAIL rst_next_op: got data=%h flags=%b lat=%0d required data=%h flags=%b lat=%0d",
                     d, f, lat, ed, ef, el);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
